// File: rtl/occ_table_mport.sv
// occ_table_mport: multi-channel occurrence-table memory for the BWT
// exact-match engine. NCH read channels share NPORT physical read ports via
// a round-robin arbiter. Single write port for table load and update.
// Optional build macro: OCC_OUT_REG_EN adds a second output register stage
// (2-cycle read latency). Default build has 1-cycle read latency.
module occ_table_mport #(
  parameter int DEPTH      = 18,
  parameter int WIDTH      = 1920,
  parameter int ADDR_WIDTH = 5,
  parameter int NCH        = 4,
  parameter int NPORT      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wEn,
  input  logic [ADDR_WIDTH-1:0]     wAddr,
  input  logic [WIDTH-1:0]          wData,
  input  logic [NCH-1:0]            req_valid,
  input  logic [NCH*ADDR_WIDTH-1:0] req_addr,
  output logic [NCH-1:0]            req_ready,
  output logic [NCH-1:0]            rsp_valid,
  output logic [NCH*WIDTH-1:0]      rsp_data,
  output logic [NCH-1:0]            rsp_err
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      memreg [DEPTH];
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_next;
  logic [NCH-1:0]        grant;
  logic [ADDR_WIDTH-1:0] ch_addr [NCH];
  logic [NCH-1:0]        in_range;
  logic [WIDTH-1:0]      rd_row [NCH];

  logic [NCH-1:0]        s1_valid;
  logic [NCH-1:0]        s1_err;
  logic [NCH*WIDTH-1:0]  s1_data;

  logic [NCH-1:0]        out_valid;
  logic [NCH-1:0]        out_err;
  logic [NCH*WIDTH-1:0]  out_data;

  // Round-robin scan from rr_ptr; first NPORT valid channels win a port.
  always_comb begin
    int cnt;
    int idx;
    grant   = '0;
    rr_next = rr_ptr;
    cnt     = 0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (req_valid[idx] && (cnt < NPORT)) begin
        grant[idx] = 1'b1;
        cnt        = cnt + 1;
        rr_next    = PTR_W'((idx + 1) % NCH);
      end
    end
  end

  // Grants are suppressed while in reset so nothing transfers then.
  assign req_ready = rst ? '0 : grant;

  // Arbiter pointer: advance past the last granted channel, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= rr_next;
    end
  end

  // Per-channel address decode and row fetch; out-of-range rows read as 0.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      in_range[i] = ({1'b0, ch_addr[i]} < DEPTH_V);
      rd_row[i]   = in_range[i] ? memreg[ch_addr[i]] : '0;
    end
  end

  // Table write; not reset, and still performed during reset.
  // Reads in the same cycle see the old row.
  always_ff @(posedge clk) begin
    if (wEn && ({1'b0, wAddr} < DEPTH_V)) begin
      memreg[wAddr] <= wData;
    end
  end

  // First response stage: capture granted rows, data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= '0;
      s1_err   <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= grant;
      s1_err   <= grant & ~in_range;
      for (int i = 0; i < NCH; i++) begin
        if (grant[i]) begin
          s1_data[i*WIDTH +: WIDTH] <= rd_row[i];
        end
      end
    end
  end

`ifdef OCC_OUT_REG_EN
  logic [NCH-1:0]       s2_valid;
  logic [NCH-1:0]       s2_err;
  logic [NCH*WIDTH-1:0] s2_data;

  // Second response stage for timing closure on wide rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= '0;
      s2_err   <= '0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_err   <= s1_err;
      s2_data  <= s1_data;
    end
  end

  assign out_valid = s2_valid;
  assign out_err   = s2_err;
  assign out_data  = s2_data;
`else
  assign out_valid = s1_valid;
  assign out_err   = s1_err;
  assign out_data  = s1_data;
`endif

  // A response still registered when rst rises is never presented.
  assign rsp_valid = out_valid & {NCH{~rst}};
  assign rsp_err   = out_err & {NCH{~rst}};
  assign rsp_data  = out_data;

endmodule

// File: tb/tb_occ_table_mport.sv
// Self-checking bench for occ_table_mport with a behavioural reference model
// (array memory, rotating-priority grant list, latency pipeline).
`timescale 1ns/1ps
module tb_occ_table_mport;

  localparam int DEPTH = 18;
  localparam int WIDTH = 1920;
  localparam int AW    = 5;
  localparam int NCH   = 4;
  localparam int NPORT = 2;
`ifdef OCC_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wEn;
  logic [AW-1:0]        wAddr;
  logic [WIDTH-1:0]     wData;
  logic [NCH-1:0]       req_valid;
  logic [NCH*AW-1:0]    req_addr;
  logic [NCH-1:0]       req_ready;
  logic [NCH-1:0]       rsp_valid;
  logic [NCH*WIDTH-1:0] rsp_data;
  logic [NCH-1:0]       rsp_err;

  occ_table_mport #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW),
                    .NCH(NCH), .NPORT(NPORT)) dut (
    .clk(clk), .rst(rst), .wEn(wEn), .wAddr(wAddr), .wData(wData),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [WIDTH-1:0] mem_m [DEPTH];
  int               ptr_m;
  logic [NCH-1:0]   s1_v, s1_e, out_v, out_e;
  logic [WIDTH-1:0] s1_d [NCH];
  logic [WIDTH-1:0] out_d [NCH];
  logic [NCH-1:0]   exp_rdy, got_rdy;

  function automatic logic [WIDTH-1:0] rand_row();
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WIDTH/32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] dut_row(input int ch);
    return rsp_data[ch*WIDTH +: WIDTH];
  endfunction

  // Build the rotation order starting at ptr and take the first NPORT valid.
  function automatic logic [NCH-1:0] model_grant(input logic [NCH-1:0] v,
                                                 input int ptr, output int last);
    int order[$];
    logic [NCH-1:0] g;
    g = '0;
    last = -1;
    for (int k = 0; k < NCH; k++) order.push_back((ptr + k) % NCH);
    foreach (order[k]) begin
      if (v[order[k]] && ($countones(g) < NPORT)) begin
        g[order[k]] = 1'b1;
        last = order[k];
      end
    end
    return g;
  endfunction

  task automatic set_req(input int ch, input int addr);
    req_valid[ch] = 1'b1;
    req_addr[ch*AW +: AW] = AW'(addr);
  endtask

  task automatic idle();
    req_valid = '0;
    wEn = 1'b0;
  endtask

  // One clock: sample req_ready mid-cycle, predict, clock, advance model.
  task automatic step();
    int last;
    int a;
    logic [NCH-1:0] g, nv, ne;
    logic [WIDTH-1:0] nd [NCH];
    @(negedge clk);
    got_rdy = req_ready;
    g = model_grant(req_valid, ptr_m, last);
    exp_rdy = rst ? '0 : g;
    for (int i = 0; i < NCH; i++) begin
      a = int'(req_addr[i*AW +: AW]);
      nv[i] = exp_rdy[i];
      ne[i] = exp_rdy[i] && (a >= DEPTH);
      nd[i] = exp_rdy[i] ? ((a < DEPTH) ? mem_m[a] : '0) : s1_d[i];
      if (rst) nd[i] = '0;
    end
    if (rst) begin
      nv = '0;
      ne = '0;
    end
    if (LAT == 2) begin
      out_v = rst ? '0 : s1_v;
      out_e = rst ? '0 : s1_e;
      for (int i = 0; i < NCH; i++) out_d[i] = rst ? '0 : s1_d[i];
    end else begin
      out_v = nv;
      out_e = ne;
      for (int i = 0; i < NCH; i++) out_d[i] = nd[i];
    end
    s1_v = nv;
    s1_e = ne;
    for (int i = 0; i < NCH; i++) s1_d[i] = nd[i];
    if (wEn && (int'(wAddr) < DEPTH)) mem_m[int'(wAddr)] = wData;
    if (rst) ptr_m = 0;
    else if (g != '0) ptr_m = (last + 1) % NCH;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_addr = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wEn = 1'b1;
      wAddr = AW'(r);
      wData = rand_row();
      step();
      n_cmp++;
      if (got_rdy !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_ready row %0d: got %b want 0000", r, got_rdy);
      end
      n_cmp++;
      if (rsp_valid !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_rsp_valid row %0d: got %b want 0000", r, rsp_valid);
      end
    end
    n_cmp++;
    if (rsp_data !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp_data: got low %h want 0", rsp_data[63:0]);
    end
    n_cmp++;
    if (rsp_err !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_rsp_err: got %b want 0000", rsp_err);
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] pat_a;
    pat_a = rand_row();
    idle();
    wEn = 1'b1; wAddr = 5'd3; wData = pat_a;
    step();
    wEn = 1'b0;
    set_req(0, 3);
    step();
    n_cmp++;
    if (got_rdy !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_ready: got %b want 0001", got_rdy);
    end
    idle();
    for (int k = 1; k < LAT; k++) begin
      n_cmp++;
      if (rsp_valid !== 4'b0000) begin
        n_bad++;
        $display("FAIL single_early_valid: got %b want 0000", rsp_valid);
      end
      step();
    end
    n_cmp++;
    if (rsp_valid !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_valid: got %b want 0001", rsp_valid);
    end
    n_cmp++;
    if (dut_row(0) !== pat_a) begin
      n_bad++;
      $display("FAIL single_data: got low %h want low %h", dut_row(0)[63:0], pat_a[63:0]);
    end
    n_cmp++;
    if (rsp_err !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_err: got %b want 0000", rsp_err);
    end
    step();
    n_cmp++;
    if (rsp_valid !== 4'b0000 || dut_row(0) !== pat_a) begin
      n_bad++;
      $display("FAIL single_hold: valid %b data low %h want 0000 / low %h",
               rsp_valid, dut_row(0)[63:0], pat_a[63:0]);
    end
  endtask

  task automatic test_fairness();
    int total;
    logic [NCH-1:0] want;
    total = 0;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4 + LAT; c++) begin
      if (c < 4) for (int ch = 0; ch < NCH; ch++) set_req(ch, $urandom_range(0, DEPTH-1));
      else idle();
      step();
      if (c < 4) begin
        want = (c % 2 == 0) ? 4'b0011 : 4'b1100;
        n_cmp++;
        if (got_rdy !== want) begin
          n_bad++;
          $display("FAIL fair_grant cycle %0d: got %b want %b", c, got_rdy, want);
        end
      end
      total += $countones(rsp_valid);
      n_cmp++;
      if (rsp_valid !== out_v) begin
        n_bad++;
        $display("FAIL fair_rsp_valid cycle %0d: got %b want %b", c, rsp_valid, out_v);
      end
      for (int ch = 0; ch < NCH; ch++) begin
        n_cmp++;
        if (dut_row(ch) !== out_d[ch]) begin
          n_bad++;
          $display("FAIL fair_data ch%0d: got low %h want low %h",
                   ch, dut_row(ch)[63:0], out_d[ch][63:0]);
        end
      end
    end
    n_cmp++;
    if (total !== 8) begin
      n_bad++;
      $display("FAIL fair_total: got %0d responses want 8", total);
    end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] pat_a, pat_b;
    logic [WIDTH-1:0] seen[$];
    pat_a = rand_row();
    pat_b = rand_row();
    idle();
    wEn = 1'b1; wAddr = 5'd5; wData = pat_a;
    step();
    wData = pat_b;
    set_req(1, 5);
    for (int c = 0; c < 2 + LAT; c++) begin
      if (c == 1) begin
        wEn = 1'b0;
        set_req(1, 5);
      end else if (c > 1) begin
        idle();
      end
      step();
      if (c < 2) begin
        n_cmp++;
        if (got_rdy !== 4'b0010) begin
          n_bad++;
          $display("FAIL collide_ready cycle %0d: got %b want 0010", c, got_rdy);
        end
      end
      if (rsp_valid[1] === 1'b1) seen.push_back(dut_row(1));
    end
    n_cmp++;
    if (seen.size() != 2) begin
      n_bad++;
      $display("FAIL collide_count: got %0d want 2", seen.size());
    end else begin
      n_cmp++;
      if (seen[0] !== pat_a) begin
        n_bad++;
        $display("FAIL collide_old: got low %h want low %h", seen[0][63:0], pat_a[63:0]);
      end
      n_cmp++;
      if (seen[1] !== pat_b) begin
        n_bad++;
        $display("FAIL collide_new: got low %h want low %h", seen[1][63:0], pat_b[63:0]);
      end
    end
  endtask

  task automatic test_out_of_range();
    idle();
    set_req(2, 20);
    step();
    idle();
    for (int k = 1; k < LAT; k++) step();
    n_cmp++;
    if (rsp_valid !== 4'b0100 || rsp_err !== 4'b0100) begin
      n_bad++;
      $display("FAIL oor_flags: valid %b err %b want 0100 0100", rsp_valid, rsp_err);
    end
    n_cmp++;
    if (dut_row(2) !== '0) begin
      n_bad++;
      $display("FAIL oor_data: got low %h want 0", dut_row(2)[63:0]);
    end
    wEn = 1'b1; wAddr = 5'd25; wData = rand_row();
    step();
    wEn = 1'b0;
    for (int r = 0; r < DEPTH + LAT; r++) begin
      idle();
      if (r < DEPTH) set_req(r % NCH, r);
      step();
      n_cmp++;
      if (rsp_valid !== out_v) begin
        n_bad++;
        $display("FAIL readback_valid step %0d: got %b want %b", r, rsp_valid, out_v);
      end
      for (int ch = 0; ch < NCH; ch++) begin
        n_cmp++;
        if (dut_row(ch) !== out_d[ch]) begin
          n_bad++;
          $display("FAIL readback_data step %0d ch%0d: got low %h want low %h",
                   r, ch, dut_row(ch)[63:0], out_d[ch][63:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    set_req(1, $urandom_range(0, DEPTH-1));
    set_req(2, $urandom_range(0, DEPTH-1));
    step();
    n_cmp++;
    if (got_rdy !== 4'b0110) begin
      n_bad++;
      $display("FAIL rstmid_accept: got %b want 0110", got_rdy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0000 || rsp_err !== 4'b0000) begin
      n_bad++;
      $display("FAIL rstmid_discard: valid %b err %b want 0000", rsp_valid, rsp_err);
    end
    step();
    n_cmp++;
    if (got_rdy !== 4'b0000) begin
      n_bad++;
      $display("FAIL rstmid_ready: got %b want 0000", got_rdy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL rstmid_after: got %b want 0000", rsp_valid);
    end
    for (int ch = 0; ch < NCH; ch++) set_req(ch, $urandom_range(0, DEPTH-1));
    step();
    n_cmp++;
    if (got_rdy !== 4'b0011) begin
      n_bad++;
      $display("FAIL rstmid_ptr: got %b want 0011", got_rdy);
    end
    idle();
    for (int k = 0; k < LAT; k++) begin
      if (k > 0) step();
      n_cmp++;
      if (rsp_valid !== out_v) begin
        n_bad++;
        $display("FAIL rstmid_valid: got %b want %b", rsp_valid, out_v);
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      n_cmp++;
      if (dut_row(ch) !== out_d[ch]) begin
        n_bad++;
        $display("FAIL rstmid_mem ch%0d: got low %h want low %h",
                 ch, dut_row(ch)[63:0], out_d[ch][63:0]);
      end
    end
    step();
  endtask

  task automatic test_random();
    logic [NCH-1:0] want_v, want_e;
    idle();
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int ch = 0; ch < NCH; ch++)
        if (!req_valid[ch] && ($urandom_range(0, 1) == 1)) set_req(ch, $urandom_range(0, 23));
      wEn = ($urandom_range(0, 2) == 0);
      wAddr = AW'($urandom_range(0, 27));
      wData = rand_row();
      step();
      n_cmp++;
      if (got_rdy !== exp_rdy) begin
        n_bad++;
        $display("FAIL rand_ready cycle %0d: got %b want %b", c, got_rdy, exp_rdy);
      end
      for (int ch = 0; ch < NCH; ch++) if (exp_rdy[ch]) req_valid[ch] = 1'b0;
      want_v = rst ? '0 : out_v;
      want_e = rst ? '0 : out_e;
      n_cmp++;
      if (rsp_valid !== want_v || rsp_err !== want_e) begin
        n_bad++;
        $display("FAIL rand_rsp cycle %0d: valid %b err %b want %b %b",
                 c, rsp_valid, rsp_err, want_v, want_e);
      end
      for (int ch = 0; ch < NCH; ch++) begin
        n_cmp++;
        if (dut_row(ch) !== out_d[ch]) begin
          n_bad++;
          $display("FAIL rand_data cycle %0d ch%0d: got low %h want low %h",
                   c, ch, dut_row(ch)[63:0], out_d[ch][63:0]);
        end
      end
    end
    rst = 1'b0;
    idle();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ptr_m = 0;
    s1_v = '0; s1_e = '0; out_v = '0; out_e = '0;
    for (int i = 0; i < NCH; i++) begin
      s1_d[i] = '0;
      out_d[i] = '0;
    end
    for (int r = 0; r < DEPTH; r++) mem_m[r] = '0;
    rst = 1'b1;
    wEn = 1'b0;
    wAddr = '0;
    wData = '0;
    req_valid = '0;
    req_addr = '0;
    test_reset();
    test_single();
    test_fairness();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
